// File: rtl/alu_pkg.sv
// Shared constants, opcode encoding and flag bit positions for the 8-bit ALU.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SLT = 4'd8
    } alu_op_e;

    // Bit positions inside the packed {N, Z, C, V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between an execute stage (master) and the ALU (slave).
interface alu_if;

    logic [alu_pkg::WIDTH-1:0] a;
    logic [alu_pkg::WIDTH-1:0] b;
    logic [3:0]                op;
    logic [alu_pkg::WIDTH-1:0] y;
    logic                      carry_out;
    logic                      overflow;
    logic                      zero;
    logic                      negative;
    logic [alu_pkg::WIDTH-1:0] y_q;
    logic [3:0]                flags_q;

    modport master (
        output a, b, op,
        input  y, carry_out, overflow, zero, negative, y_q, flags_q
    );

    modport slave (
        input  a, b, op,
        output y, carry_out, overflow, zero, negative, y_q, flags_q
    );

endinterface

// File: rtl/alu_addsub.sv
// Shared adder: subtraction is a + ~b + 1, so one carry chain serves ADD, SUB and SLT.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   full;

    assign bEff  = sub_i ? ~b_i : b_i;
    assign full  = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub_i};

    assign sum_o   = full[WIDTH-1:0];
    assign carry_o = full[WIDTH];

    // Overflow when both addends share a sign the result does not.
    assign overflow_o = (a_i[WIDTH-1] == bEff[WIDTH-1]) &&
                        (full[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_8bit.sv
// 8-bit ALU with combinational result/flags and a one-cycle registered copy.
module alu_8bit
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    logic [WIDTH-1:0] sum;
    logic             addCarry;
    logic             addOverflow;
    logic             useSub;
    logic             lessThan;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] yComb;
    logic             carryComb;
    logic             overflowComb;

    logic [WIDTH-1:0] yReg_d;
    logic [WIDTH-1:0] yReg_q;
    logic [3:0]       flagsReg_d;
    logic [3:0]       flagsReg_q;

    assign useSub = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    assign shamt  = bus.b[SHW-1:0];

    alu_addsub u_addsub (
        .a_i        (bus.a),
        .b_i        (bus.b),
        .sub_i      (useSub),
        .sum_o      (sum),
        .carry_o    (addCarry),
        .overflow_o (addOverflow)
    );

    // Signed a < b: the sign of a - b, corrected when that subtraction overflowed.
    assign lessThan = sum[WIDTH-1] ^ addOverflow;

    always_comb begin
        yComb        = '0;
        carryComb    = 1'b0;
        overflowComb = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                yComb        = sum;
                carryComb    = addCarry;
                overflowComb = addOverflow;
            end
            OP_AND:  yComb = bus.a & bus.b;
            OP_OR:   yComb = bus.a | bus.b;
            OP_XOR:  yComb = bus.a ^ bus.b;
            OP_NOR:  yComb = ~(bus.a | bus.b);
            OP_SLL:  yComb = bus.a << shamt;
            OP_SRL:  yComb = bus.a >> shamt;
            OP_SLT:  yComb = {{(WIDTH-1){1'b0}}, lessThan};
            default: yComb = '0;
        endcase
    end

    assign bus.y         = yComb;
    assign bus.carry_out = carryComb;
    assign bus.overflow  = overflowComb;
    assign bus.zero      = (yComb == '0);
    assign bus.negative  = yComb[WIDTH-1];

    always_comb begin
        flagsReg_d         = '0;
        flagsReg_d[FLAG_N] = yComb[WIDTH-1];
        flagsReg_d[FLAG_Z] = (yComb == '0);
        flagsReg_d[FLAG_C] = carryComb;
        flagsReg_d[FLAG_V] = overflowComb;
    end

    assign yReg_d = yComb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yReg_q     <= '0;
            flagsReg_q <= '0;
        end else begin
            yReg_q     <= yReg_d;
            flagsReg_q <= flagsReg_d;
        end
    end

    assign bus.y_q     = yReg_q;
    assign bus.flags_q = flagsReg_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed and random self-checking bench for alu_8bit, combinational and registered paths.
module tb_alu_8bit;

    logic clk;
    logic rst_n;
    int   vecCount;
    int   missCount;

    alu_if bus ();

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] y;
        logic [3:0] flags;
    } vec_t;

    // Expected flags are {N, Z, C, V}, worked out by hand.
    vec_t vecs [17] = '{
        '{8'h7F, 8'h01, 4'd0, 8'h80, 4'b1001},
        '{8'h80, 8'hFF, 4'd0, 8'h7F, 4'b0011},
        '{8'hFF, 8'h01, 4'd0, 8'h00, 4'b0110},
        '{8'h00, 8'h00, 4'd1, 8'h00, 4'b0110},
        '{8'h00, 8'h01, 4'd1, 8'hFF, 4'b1000},
        '{8'h80, 8'h01, 4'd1, 8'h7F, 4'b0011},
        '{8'hF0, 8'h3C, 4'd2, 8'h30, 4'b0000},
        '{8'hF0, 8'h0F, 4'd3, 8'hFF, 4'b1000},
        '{8'hFF, 8'h0F, 4'd4, 8'hF0, 4'b1000},
        '{8'h00, 8'h00, 4'd5, 8'hFF, 4'b1000},
        '{8'h01, 8'h01, 4'd6, 8'h02, 4'b0000},
        '{8'hFF, 8'h01, 4'd7, 8'h7F, 4'b0000},
        '{8'hFF, 8'h09, 4'd7, 8'h7F, 4'b0000},
        '{8'hFE, 8'hFF, 4'd8, 8'h01, 4'b0000},
        '{8'h01, 8'hFF, 4'd8, 8'h00, 4'b0100},
        '{8'h12, 8'h34, 4'd9, 8'h00, 4'b0100},
        '{8'hFF, 8'hFF, 4'd15, 8'h00, 4'b0100}
    };

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
        #1;
    endtask

    // Reference built from wide signed/unsigned arithmetic rather than an adder chain.
    function automatic void refModel(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] op, output logic [7:0] y,
                                     output logic [3:0] flags);
        int sa;
        int sb;
        int sr;
        logic c;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd0: begin
                y  = 8'(int'(a) + int'(b));
                c  = (int'(a) + int'(b)) > 255;
                sr = sa + sb;
                v  = (sr > 127) || (sr < -128);
            end
            4'd1: begin
                y  = 8'(int'(a) - int'(b));
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > 127) || (sr < -128);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = ~(a | b);
            4'd6: y = 8'(int'(a) * (1 << int'(b[2:0])));
            4'd7: y = 8'(int'(a) / (1 << int'(b[2:0])));
            4'd8: y = (sa < sb) ? 8'h01 : 8'h00;
            default: y = 8'h00;
        endcase
        flags = {y[7], (y == 8'h00), c, v};
    endfunction

    initial begin
        logic [7:0] expY;
        logic [3:0] expF;
        vecCount  = 0;
        missCount = 0;
        rst_n     = 1'b0;
        applyStimulus(8'h00, 8'h00, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset y_q", 32'(bus.y_q), 32'h00);
        checkOutput("reset flags_q", 32'(bus.flags_q), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            checkOutput($sformatf("vec%0d y", i), 32'(bus.y), 32'(vecs[i].y));
            checkOutput($sformatf("vec%0d flags", i),
                        32'({bus.negative, bus.zero, bus.carry_out, bus.overflow}),
                        32'(vecs[i].flags));
        end

        // Registered path then an asynchronous reset pulse between edges.
        @(negedge clk);
        applyStimulus(8'h7F, 8'h01, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reg y_q", 32'(bus.y_q), 32'h80);
        checkOutput("reg flags_q", 32'(bus.flags_q), 32'b1001);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async y_q", 32'(bus.y_q), 32'h00);
        checkOutput("async flags_q", 32'(bus.flags_q), 32'h0);
        checkOutput("comb y in reset", 32'(bus.y), 32'h80);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            applyStimulus(8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)));
            refModel(bus.a, bus.b, bus.op, expY, expF);
            checkOutput($sformatf("rnd%0d y", i), 32'(bus.y), 32'(expY));
            checkOutput($sformatf("rnd%0d cv", i),
                        32'({bus.carry_out, bus.overflow}), 32'(expF[1:0]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d y_q", i), 32'(bus.y_q), 32'(expY));
            checkOutput($sformatf("rnd%0d flags_q", i), 32'(bus.flags_q), 32'(expF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Combinational 8-bit integer ALU (add/sub, bitwise logic, shifts, signed set-less-than) with NZCV-style flags, for use in datapath execute stages.
- Primary outputs are purely combinational from a, b and op; zero clock latency.
- A registered copy of the result and flags (one-cycle latency) is also provided for pipelined consumers, clocked by clk and reset by rst_n.

Parameters:
- WIDTH, 8, operand/result width; the block is specified and verified at 8 only.
- SHW, 3, shift-amount width (log2 WIDTH); the shift amount is b[SHW-1:0].

Ports:
- clk  input  1  single clock; drives only the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  8  operand A (two's complement for signed ops).
- b  input  8  operand B; b[2:0] is the shift amount.
- op  input  4  operation select.
- y  output  8  combinational result.
- carry_out  output  1  combinational carry (ADD/SUB only).
- overflow  output  1  combinational signed overflow (ADD/SUB only).
- zero  output  1  combinational, (y == 0).
- negative  output  1  combinational, y[7].
- y_q  output  8  registered y.
- flags_q  output  4  registered {negative, zero, carry_out, overflow}.

Behaviour:
- Op encoding:
  - 0000 ADD: y = a+b (mod 256); carry_out = bit 8 of the 9-bit sum; overflow = (a[7]==b[7]) && (y[7]!=a[7]).
  - 0001 SUB: computed as a + ~b + 1; carry_out = bit 8 (1 = no borrow, so 0-0 gives carry 1); overflow = (a[7]!=b[7]) && (y[7]!=a[7]).
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOR: ~(a|b).
  - 0110 SLL: a << b[2:0], zero fill; b[7:3] ignored.
  - 0111 SRL: a >> b[2:0], logical (zero fill), not arithmetic.
  - 1000 SLT: y = 8'h01 if signed(a) < signed(b), else 8'h00.
  - 1001–1111: y = 8'h00.
- carry_out = 0 and overflow = 0 for every op other than ADD/SUB.
- zero and negative are derived from y for every op, including SLT and undefined ops (undefined op gives zero=1, negative=0).
- Combinational outputs carry no X for any known input; no latches; all outputs assigned for every op.
- Registered path:
  - On each rising clk, y_q <= y and flags_q <= {negative, zero, carry_out, overflow}.
  - No enable; one-cycle latency.
- Reset:
  - rst_n low asynchronously clears y_q and flags_q to 0, regardless of clk.
  - Combinational outputs are unaffected by reset.
  - Registers resume capture on the first rising clk after rst_n deasserts.

Decomposition:
- Package alu_pkg: 4-bit op enum (OP_ADD..OP_SLT), WIDTH/SHW constants, and flag bit indices (N=3, Z=2, C=1, V=0).
- One natural sub-module, alu_addsub: a shared 9-bit adder with a sub control that inverts b and injects carry-in 1. It outputs sum, carry and overflow; SLT reuses its SUB result (lt = sum[7] ^ overflow).
- Logic, shift, result mux and flag register stay in alu_8bit.

Test Plan:
- ADD edges: a=7F,b=01 -> y=80,c=0,v=1,n=1,z=0. a=80,b=FF -> y=7F,c=1,v=1. a=FF,b=01 -> y=00,c=1,v=0,z=1.
- SUB: 00-00 -> y=00,c=1,v=0,z=1. 00-01 -> y=FF,c=0,v=0,n=1. 80-01 -> y=7F,c=1,v=1.
- Logic/shift/SLT/undefined:
  - SLL 01 by 01 -> 02.
  - SRL FF by 01 -> 7F; SRL FF by 09 (b[2:0]=1) -> 7F.
  - SLT FE,FF -> 01; SLT 01,FF -> 00 with z=1.
  - NOR 00,00 -> FF.
  - op=1001 -> y=00,z=1,c=0,v=0.
- Registered path: apply a=7F,b=01,ADD; after one rising clk, y_q=80 and flags_q=4'b1001. Pulse rst_n low mid-cycle -> y_q=00 and flags_q=0 immediately, without waiting for a clock edge.
- Random sweep: at least 2000 random a, b and op in 0..8, checked against a 9-bit reference model on y, carry_out and overflow after settle, and on y_q/flags_q one cycle later.
